// File: rtl/rc_adc_pkg.sv
// Shared definitions for the multi-channel RC-discharge potentiometer scanner.
package rc_adc_pkg;

    // Scanner FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHARGE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_RESULT  = 2'd3
    } rc_state_t;

    // Default number of cycles the RC node is driven high before measuring.
    localparam int DEF_CHARGE_TICKS = 240000;

    // Default channel count and counter width.
    localparam int DEF_NCH = 4;
    localparam int DEF_CW  = 24;

endpackage

// File: rtl/rc_sync.sv
// Two-flop synchronizer for the raw RC node reads. It resets to 1 so that an
// idle (charged) node is assumed until real samples arrive.
module rc_sync #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two-stage capture of the asynchronous pin values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rc_adc_scan.sv
// Multi-channel RC-discharge potentiometer reader. Each channel in turn is
// charged through its drive-high pin, released, and the number of clock
// cycles until the synchronized node reads low is reported as one result.
module rc_adc_scan
    import rc_adc_pkg::*;
#(
    parameter int             NCH          = DEF_NCH,
    parameter int             CW           = DEF_CW,
    parameter int             CHARGE_TICKS = DEF_CHARGE_TICKS,
    parameter logic [CW-1:0]  TIMEOUT      = {CW{1'b1}},
    parameter int             CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clki,
    input  logic            resetn,
    input  logic            en,
    input  logic [NCH-1:0]  rc_in,
    output logic [NCH-1:0]  drive_hi,
    output logic            busy,
    output logic            res_valid,
    output logic [CHW-1:0]  res_ch,
    output logic [CW-1:0]   res_count,
    output logic            res_timeout
);

    // Last accumulator value of the charge phase and last channel index.
    localparam logic [CW-1:0]  CT_LAST = CW'(CHARGE_TICKS - 1);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

    // Synchronized node levels; every decision uses these, never rc_in.
    logic [NCH-1:0] w_sync;

    rc_sync #(
        .W (NCH)
    ) u_rc_sync (
        .i_clk   (clki),
        .i_rst_n (resetn),
        .i_d     (rc_in),
        .o_q     (w_sync)
    );

    rc_state_t      r_state;
    rc_state_t      w_state_nxt;
    logic [CW-1:0]  r_acc;
    logic [CW-1:0]  w_acc_nxt;
    logic [CHW-1:0] r_ch;
    logic [CHW-1:0] w_ch_nxt;
    logic [NCH-1:0] r_drive_hi;
    logic [NCH-1:0] w_drive_hi_nxt;
    logic           r_busy;
    logic           r_res_valid;
    logic           w_res_valid_nxt;
    logic [CHW-1:0] r_res_ch;
    logic [CHW-1:0] w_res_ch_nxt;
    logic [CW-1:0]  r_res_count;
    logic [CW-1:0]  w_res_count_nxt;
    logic           r_res_timeout;
    logic           w_res_timeout_nxt;
    logic [NCH-1:0] w_ch_onehot;
    logic           w_node_low;

    // One-hot select of the channel currently being scanned.
    always_comb begin
        w_ch_onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            w_ch_onehot[i] = (r_ch == CHW'(i));
        end
    end

    assign w_node_low = ~w_sync[r_ch];

    // Next-state, counter, channel rotation and result capture.
    always_comb begin
        w_state_nxt       = r_state;
        w_acc_nxt         = r_acc;
        w_ch_nxt          = r_ch;
        w_drive_hi_nxt    = '0;
        w_res_valid_nxt   = 1'b0;
        w_res_ch_nxt      = r_res_ch;
        w_res_count_nxt   = r_res_count;
        w_res_timeout_nxt = r_res_timeout;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_CHARGE;
                    w_acc_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_CHARGE: begin
                // Pin is driven from the cycle after CHARGE entry up to and
                // including the first MEASURE cycle, i.e. CHARGE_TICKS cycles.
                w_drive_hi_nxt = w_ch_onehot;
                if (r_acc == CT_LAST) begin
                    w_acc_nxt   = '0;
                    w_state_nxt = ST_MEASURE;
                end else begin
                    w_acc_nxt   = r_acc + CW'(1'b1);
                end
            end

            ST_MEASURE: begin
                if (w_node_low) begin
                    w_res_count_nxt   = r_acc;
                    w_res_timeout_nxt = 1'b0;
                    w_res_valid_nxt   = 1'b1;
                    w_res_ch_nxt      = r_ch;
                    w_state_nxt       = ST_RESULT;
                end else if (r_acc == TIMEOUT) begin
                    // Saturate rather than wrap: a missing discharge is flagged.
                    w_res_count_nxt   = TIMEOUT;
                    w_res_timeout_nxt = 1'b1;
                    w_res_valid_nxt   = 1'b1;
                    w_res_ch_nxt      = r_ch;
                    w_state_nxt       = ST_RESULT;
                end else begin
                    w_acc_nxt = r_acc + CW'(1'b1);
                end
            end

            ST_RESULT: begin
                // Advance now so a restart from IDLE resumes at the next channel.
                if (r_ch == CH_LAST) begin
                    w_ch_nxt = '0;
                end else begin
                    w_ch_nxt = r_ch + CHW'(1'b1);
                end
                w_acc_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_CHARGE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_acc_nxt   = '0;
            end
        endcase
    end

    // State register plus all registered outputs; reset clears drive_hi at once.
    always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_ch          <= '0;
            r_drive_hi    <= '0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= '0;
            r_res_count   <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_ch          <= w_ch_nxt;
            r_drive_hi    <= w_drive_hi_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_res_valid   <= w_res_valid_nxt;
            r_res_ch      <= w_res_ch_nxt;
            r_res_count   <= w_res_count_nxt;
            r_res_timeout <= w_res_timeout_nxt;
        end
    end

    assign drive_hi    = r_drive_hi;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_count   = r_res_count;
    assign res_timeout = r_res_timeout;

endmodule

// File: tb/tb_rc_adc_scan.sv
// Self-checking bench for rc_adc_scan (NCH=2, CW=8, CHARGE_TICKS=8). The pot
// pins are modelled by the bench: a node reads high until the bench releases
// it at a chosen MEASURE cycle k, and the expected count is k+2 (two-flop
// synchronizer), or 255 with timeout when it is never released.
module tb_rc_adc_scan;

    localparam int NCH     = 2;
    localparam int CW      = 8;
    localparam int CT      = 8;
    localparam int TMO     = 255;

    logic           clki;
    logic           resetn;
    logic           en;
    logic [NCH-1:0] rc_in;
    logic [NCH-1:0] drive_hi;
    logic           busy;
    logic           res_valid;
    logic [0:0]     res_ch;
    logic [CW-1:0]  res_count;
    logic           res_timeout;

    int n_checks;
    int n_errors;
    int exp_ch;
    int n_strobes;
    bit prev_valid;

    rc_adc_scan #(
        .NCH          (NCH),
        .CW           (CW),
        .CHARGE_TICKS (CT)
    ) dut (
        .clki        (clki),
        .resetn      (resetn),
        .en          (en),
        .rc_in       (rc_in),
        .drive_hi    (drive_hi),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ch      (res_ch),
        .res_count   (res_count),
        .res_timeout (res_timeout)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    // Strobe monitor: never two valid cycles in a row; counts strobes.
    always @(negedge clki) begin
        if (!resetn) begin
            prev_valid = 1'b0;
        end else begin
            if (res_valid) begin
                n_strobes++;
                n_checks++;
                if (prev_valid) begin
                    n_errors++;
                    $display("FAIL strobe_consecutive: res_valid high 2 cycles in a row (required 1 cycle)");
                end
            end
            prev_valid = res_valid;
        end
    end

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    // One channel visit: checks the charge pulse, releases the node at MEASURE
    // cycle k (or never), and checks the delivered result.
    task automatic do_visit(input int k, input bit hold_high, input bit drop_en);
        int n;
        int exp_cnt;
        bit exp_to;
        logic [NCH-1:0] exp_drv;
        exp_drv = NCH'(1 << exp_ch);
        if (hold_high || (k + 2 > TMO)) begin
            exp_cnt = TMO;
            exp_to  = 1'b1;
        end else begin
            exp_cnt = k + 2;
            exp_to  = 1'b0;
        end
        n = 0;
        while (drive_hi == '0 && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (drive_hi !== exp_drv) begin
            n_errors++;
            $display("FAIL charge_start: drive_hi=%b required %b (ch %0d)", drive_hi, exp_drv, exp_ch);
        end
        for (int i = 1; i < CT; i++) begin
            step();
            n_checks++;
            if (drive_hi !== exp_drv) begin
                n_errors++;
                $display("FAIL charge_hold: cycle %0d drive_hi=%b required %b", i, drive_hi, exp_drv);
            end
        end
        // Now in MEASURE cycle 0.
        if (!hold_high && k == 0) rc_in[exp_ch] = 1'b0;
        step();
        n_checks++;
        if (drive_hi !== '0) begin
            n_errors++;
            $display("FAIL charge_len: drive_hi=%b after %0d cycles, required 00", drive_hi, CT);
        end
        if (drop_en) en = 1'b0;
        if (!hold_high && k >= 1) begin
            for (int i = 1; i < k; i++) step();
            rc_in[exp_ch] = 1'b0;
        end
        n = 0;
        while (!res_valid && n < 400) begin
            step();
            n++;
        end
        n_checks++;
        if (!res_valid) begin
            n_errors++;
            $display("FAIL result_wait: res_valid=%b after 400 cycles, required 1", res_valid);
        end
        n_checks++;
        if (res_ch !== 1'(exp_ch) || res_count !== CW'(exp_cnt) || res_timeout !== exp_to) begin
            n_errors++;
            $display("FAIL result: ch=%0d count=%0d to=%b required ch=%0d count=%0d to=%b",
                     res_ch, res_count, res_timeout, exp_ch, exp_cnt, exp_to);
        end
        rc_in[exp_ch] = 1'b1;
        step();
        n_checks++;
        if (res_valid !== 1'b0 || res_count !== CW'(exp_cnt)) begin
            n_errors++;
            $display("FAIL result_hold: valid=%b count=%0d required valid=0 count=%0d",
                     res_valid, res_count, exp_cnt);
        end
        exp_ch = (exp_ch + 1) % NCH;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        en     = 1'b0;
        rc_in  = '1;
        repeat (3) step();
        n_checks++;
        if (drive_hi !== '0 || busy !== 1'b0 || res_valid !== 1'b0 ||
            res_ch !== 1'b0 || res_count !== '0 || res_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: drv=%b busy=%b v=%b ch=%0d cnt=%0d to=%b required all 0",
                     drive_hi, busy, res_valid, res_ch, res_count, res_timeout);
        end
        @(negedge clki);
        resetn = 1'b1;
        repeat (4) step();
        n_checks++;
        if (busy !== 1'b0 || drive_hi !== '0) begin
            n_errors++;
            $display("FAIL idle_no_en: busy=%b drive_hi=%b required 0/00", busy, drive_hi);
        end
        exp_ch = 0;
    endtask

    task automatic test_basic();
        en = 1'b1;
        do_visit(5, 1'b0, 1'b0);   // ch0, count 7
        do_visit(0, 1'b0, 1'b0);   // ch1, count 2, then wraps to ch0
    endtask

    task automatic test_timeout();
        do_visit(0, 1'b1, 1'b0);   // ch0 never discharges
        do_visit($urandom_range(1, 30), 1'b0, 1'b0);  // scan continues on ch1
    endtask

    task automatic test_en_drop();
        do_visit($urandom_range(1, 20), 1'b0, 1'b1);  // ch0, en dropped mid-measure
        n_checks++;
        if (busy !== 1'b0 || drive_hi !== '0) begin
            n_errors++;
            $display("FAIL en_drop_idle: busy=%b drive_hi=%b required 0/00", busy, drive_hi);
        end
        repeat (6) step();
        n_checks++;
        if (busy !== 1'b0 || drive_hi !== '0 || res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL en_drop_stay: busy=%b drive_hi=%b valid=%b required 0/00/0",
                     busy, drive_hi, res_valid);
        end
        en = 1'b1;
        do_visit($urandom_range(1, 20), 1'b0, 1'b0);  // resumes on ch1
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (drive_hi == '0 && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (drive_hi !== '0 || busy !== 1'b0 || res_valid !== 1'b0 ||
            res_ch !== 1'b0 || res_count !== '0 || res_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: drv=%b busy=%b v=%b ch=%0d cnt=%0d to=%b required all 0",
                     drive_hi, busy, res_valid, res_ch, res_count, res_timeout);
        end
        rc_in = '1;
        repeat (2) @(negedge clki);
        resetn = 1'b1;
        exp_ch = 0;
        do_visit($urandom_range(1, 40), 1'b0, 1'b0);  // restarts on ch0
    endtask

    task automatic test_back_to_back();
        int s0;
        int nv;
        s0 = n_strobes;
        nv = 6;
        for (int i = 0; i < nv; i++) begin
            do_visit($urandom_range(0, 100), 1'b0, 1'b0);
        end
        n_checks++;
        if (n_strobes - s0 !== nv) begin
            n_errors++;
            $display("FAIL strobe_count: %0d strobes required %0d", n_strobes - s0, nv);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_strobes = 0;
        exp_ch    = 0;
        test_reset();
        test_basic();
        test_timeout();
        // ch0 visit with res_count becoming nonzero before the reset check
        test_en_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
